// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the CPU data bus.
// Register window: 0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV, 0xC reserved.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Memwrite,
    input  logic [31:0] Memaddr,
    input  logic [31:0] MemWdata,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        uart_txd
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   bauddiv;
    logic [15:0]   div_q;
    logic [15:0]   bit_cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    state_t        state;

    logic fifo_full;
    logic fifo_empty;
    logic busy;
    logic wr_tx;
    logic wr_status;
    logic wr_baud;
    logic push;
    logic pop;
    logic bit_done;
    logic unused_bits;

    assign sel        = (Memaddr[31:4] == BASE_ADDR[31:4]);
    assign wr_tx      = Memwrite & sel & (Memaddr[3:2] == 2'd0);
    assign wr_status  = Memwrite & sel & (Memaddr[3:2] == 2'd1);
    assign wr_baud    = Memwrite & sel & (Memaddr[3:2] == 2'd2);
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign busy       = (state != IDLE);
    assign bit_done   = (bit_cnt == div_q - 16'd1);

    // Fullness uses the pre-edge count, so a same-cycle pop never rescues a write.
    assign push = wr_tx & ~fifo_full;
    assign pop  = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done));

    assign unused_bits = ^{Memaddr[1:0], MemWdata[31:16]};

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (Memaddr[3:2])
                2'd1:    rdata = {23'd0, 5'(count), overflow, busy, fifo_empty, fifo_full};
                2'd2:    rdata = {16'd0, bauddiv};
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= MemWdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            bauddiv  <= DEFAULT_DIV;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_tx & fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_status & MemWdata[3]) begin
                overflow <= 1'b0;
            end
            if (wr_baud) begin
                bauddiv <= (MemWdata[15:0] == 16'd0) ? 16'd1 : MemWdata[15:0];
            end
        end
    end

    // Divider is latched per frame so BAUDDIV writes only affect the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            uart_txd <= 1'b1;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            div_q    <= DEFAULT_DIV;
        end else begin
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    bit_cnt  <= '0;
                    if (pop) begin
                        shift    <= fifo_mem[rd_ptr];
                        div_q    <= bauddiv;
                        uart_txd <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        uart_txd <= shift[0];
                        state    <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_txd <= 1'b1;
                            state    <= STOP;
                        end else begin
                            shift    <= {1'b0, shift[7:1]};
                            uart_txd <= shift[1];
                            bit_idx  <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift    <= fifo_mem[rd_ptr];
                            div_q    <= bauddiv;
                            uart_txd <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: begin
                    uart_txd <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio: register access, framing,
// back-to-back frames, overflow, divider handling, reset and address decode.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_TX = BASE;
    localparam logic [31:0] A_ST = BASE + 32'd4;
    localparam logic [31:0] A_BD = BASE + 32'd8;
    localparam logic [31:0] A_RS = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic        Memwrite;
    logic [31:0] Memaddr;
    logic [31:0] MemWdata;
    logic        sel;
    logic [31:0] rdata;
    logic        uart_txd;

    int errors = 0;
    int checks = 0;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd434)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Memwrite(Memwrite),
        .Memaddr (Memaddr),
        .MemWdata(MemWdata),
        .sel     (sel),
        .rdata   (rdata),
        .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    // Write lands on the next rising edge; returns 1ns after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Memaddr  = a;
        MemWdata = d;
        Memwrite = 1'b1;
        @(posedge clk);
        #1;
        Memwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        Memaddr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd: got %b expected 1", uart_txd); end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00000002", r); end
        checks++;
        if (sel !== 1'b1) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 1", sel); end
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd434) begin errors++; $display("[TB] FAIL reset_baud: got %0d expected 434", r); end
        bus_read(A_TX, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("[TB] FAIL reset_txdata_read: got %h expected 0", r); end
    endtask

    task automatic test_single_frame();
        logic [31:0] r;
        logic [9:0]  frame;
        logic        exp;
        frame = {1'b1, 8'h55, 1'b0};
        bus_write(A_BD, 32'd4);
        bus_write(A_TX, 32'h55);
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("[TB] FAIL single_txd_at_E: got %b expected 1", uart_txd); end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h10) begin errors++; $display("[TB] FAIL single_count_at_E: got %h expected 00000010", r); end
        for (int i = 0; i <= 40; i++) begin
            @(posedge clk);
            #1;
            bus_read(A_ST, r);
            exp = (i < 40) ? frame[i / 4] : 1'b1;
            checks++;
            if (uart_txd !== exp) begin errors++; $display("[TB] FAIL single_txd[%0d]: got %b expected %b", i, uart_txd, exp); end
            checks++;
            if (r[2] !== (i < 40)) begin errors++; $display("[TB] FAIL single_busy[%0d]: got %b expected %b", i, r[2], (i < 40)); end
            if (i == 0) begin
                checks++;
                if (r !== 32'h6) begin errors++; $display("[TB] FAIL single_status_pop: got %h expected 00000006", r); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [7:0]  data_q [3];
        logic [9:0]  frame;
        logic        exp;
        data_q = '{8'hA5, 8'h0F, 8'hFF};
        bus_write(A_BD, 32'd2);
        bus_write(A_TX, 32'hA5);
        bus_write(A_TX, 32'h0F);
        checks++;
        if (uart_txd !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start: got %b expected 0", uart_txd); end
        bus_write(A_TX, 32'hFF);
        for (int i = 1; i <= 60; i++) begin
            bus_read(A_ST, r);
            if (i < 60) begin
                frame = {1'b1, data_q[i / 20], 1'b0};
                exp   = frame[(i % 20) / 2];
            end else begin
                exp = 1'b1;
            end
            checks++;
            if (uart_txd !== exp) begin errors++; $display("[TB] FAIL b2b_txd[%0d]: got %b expected %b", i, uart_txd, exp); end
            if (i == 1 || i == 20 || i == 40) begin
                checks++;
                if (r[8:4] !== ((i == 1) ? 5'd2 : (i == 20) ? 5'd1 : 5'd0)) begin
                    errors++;
                    $display("[TB] FAIL b2b_count[%0d]: got %0d expected %0d", i, r[8:4], (i == 1) ? 2 : (i == 20) ? 1 : 0);
                end
            end
            if (i == 60) begin
                checks++;
                if (r !== 32'h2) begin errors++; $display("[TB] FAIL b2b_idle_status: got %h expected 00000002", r); end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        logic [7:0]  b;
        logic [9:0]  frame;
        logic        exp;
        bus_write(A_BD, 32'd100);
        for (int k = 0; k < 10; k++) begin
            bus_write(A_TX, 32'h10 + k);
        end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h8D) begin errors++; $display("[TB] FAIL ovf_status: got %h expected 0000008d", r); end
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h85) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected 00000085", r); end
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd100) begin errors++; $display("[TB] FAIL ovf_baud_kept: got %0d expected 100", r); end
        // Faster divider drains the eight stored bytes once the first frame ends.
        bus_write(A_BD, 32'd1);
        repeat (989) @(posedge clk);
        #1;
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("[TB] FAIL ovf_first_stop: got %b expected 1", uart_txd); end
        for (int i = 0; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (i < 80) begin
                b     = 8'h11 + 8'(i / 10);
                frame = {1'b1, b, 1'b0};
                exp   = frame[i % 10];
            end else begin
                exp = 1'b1;
            end
            checks++;
            if (uart_txd !== exp) begin errors++; $display("[TB] FAIL ovf_drain_txd[%0d]: got %b expected %b", i, uart_txd, exp); end
        end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("[TB] FAIL ovf_drained_status: got %h expected 00000002", r); end
    endtask

    task automatic test_baud_zero();
        logic [31:0] r;
        logic [9:0]  f1;
        logic [9:0]  f2;
        logic        exp;
        f1 = {1'b1, 8'hC3, 1'b0};
        f2 = {1'b1, 8'h3C, 1'b0};
        bus_write(A_BD, 32'd3);
        bus_write(A_BD, 32'd0);
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd1) begin errors++; $display("[TB] FAIL baud_zero: got %0d expected 1", r); end
        bus_write(A_TX, 32'hC3);
        bus_write(A_TX, 32'h3C);
        checks++;
        if (uart_txd !== 1'b0) begin errors++; $display("[TB] FAIL baud_start: got %b expected 0", uart_txd); end
        bus_write(A_BD, 32'd8);
        for (int i = 1; i <= 90; i++) begin
            bus_read(A_ST, r);
            if (i < 10)      exp = f1[i];
            else if (i < 90) exp = f2[(i - 10) / 8];
            else             exp = 1'b1;
            checks++;
            if (uart_txd !== exp) begin errors++; $display("[TB] FAIL baud_txd[%0d]: got %b expected %b", i, uart_txd, exp); end
            if (i == 10 || i == 90) begin
                checks++;
                if (r[2] !== (i == 10)) begin errors++; $display("[TB] FAIL baud_busy[%0d]: got %b expected %b", i, r[2], (i == 10)); end
            end
            @(posedge clk);
            #1;
        end
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd8) begin errors++; $display("[TB] FAIL baud_readback8: got %0d expected 8", r); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        int          bad;
        bus_write(A_BD, 32'd4);
        for (int k = 0; k < 4; k++) begin
            bus_write(A_TX, 32'h81 + k);
        end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h34) begin errors++; $display("[TB] FAIL rst_queued: got %h expected 00000034", r); end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (uart_txd !== 1'b0) begin errors++; $display("[TB] FAIL rst_data_bit1: got %b expected 0", uart_txd); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("[TB] FAIL rst_txd: got %b expected 1", uart_txd); end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("[TB] FAIL rst_status: got %h expected 00000002", r); end
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd434) begin errors++; $display("[TB] FAIL rst_baud: got %0d expected 434", r); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            bus_read(A_ST, r);
            if (uart_txd !== 1'b1 || r[2] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL rst_quiet: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_window();
        logic [31:0] r;
        bus_read(A_RS, r);
        checks++;
        if (r !== 32'h0 || sel !== 1'b1) begin errors++; $display("[TB] FAIL win_reserved_read: got %h sel %b expected 0 sel 1", r, sel); end
        bus_read(BASE + 32'd6, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("[TB] FAIL win_byte_offset: got %h expected 00000002", r); end
        bus_read(BASE + 32'd16, r);
        checks++;
        if (r !== 32'h0 || sel !== 1'b0) begin errors++; $display("[TB] FAIL win_outside_hi: got %h sel %b expected 0 sel 0", r, sel); end
        bus_read(32'hFFFE_0008, r);
        checks++;
        if (r !== 32'h0 || sel !== 1'b0) begin errors++; $display("[TB] FAIL win_outside_lo: got %h sel %b expected 0 sel 0", r, sel); end
        bus_write(A_RS, 32'hFFFF_FFFF);
        bus_write(BASE + 32'd16, 32'h5A);
        bus_write(32'hFFFE_0008, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("[TB] FAIL win_txd: got %b expected 1", uart_txd); end
        bus_read(A_ST, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("[TB] FAIL win_status: got %h expected 00000002", r); end
        bus_read(A_BD, r);
        checks++;
        if (r !== 32'd434) begin errors++; $display("[TB] FAIL win_baud: got %0d expected 434", r); end
    endtask

    initial begin
        reset    = 1'b1;
        Memwrite = 1'b0;
        Memaddr  = '0;
        MemWdata = '0;
        $display("[TB] starting uart_tx_mmio tests");
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_baud_zero();
        test_reset_midframe();
        test_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
